// File: rtl/mc_ctrl.sv
// Multi-cycle controller for the MIPS-subset datapath: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives all datapath selects and write enables.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             mem_ready,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic             RegDst,
    output logic             AluSrc,
    output logic             MemToReg,
    output logic             beq,
    output logic             bgtz,
    output logic             jal,
    output logic             jr,
    output logic             GPR_Write,
    output logic             DM_Write,
    output logic             LuiExt,
    output logic             SignExt,
    output logic [2:0]       ALUOp,
    output logic             retire,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_BGTZ, C_JAL, C_ILL
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] op;
    logic [5:0] funct;
    assign op    = Instr[31:26];
    assign funct = Instr[5:0];

    always_comb begin
        dec_cls = C_ILL;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: dec_cls = C_ADDU;
                    6'b100011: dec_cls = C_SUBU;
                    6'b001000: dec_cls = C_JR;
                    default:   dec_cls = C_ILL;
                endcase
            end
            6'b001101: dec_cls = C_ORI;
            6'b001111: dec_cls = C_LUI;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b000111: dec_cls = C_BGTZ;
            6'b000011: dec_cls = C_JAL;
            default:   dec_cls = C_ILL;
        endcase
    end

    // The class is also captured leaving FETCH so DECODE can already drive
    // selects (and flag illegal) from a register instead of from Instr.
    always_comb begin
        cls_d = cls_q;
        if (state_q == S_FETCH || state_q == S_DECODE) begin
            cls_d = dec_cls;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (cls_q == C_ILL) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW:                   state_d = S_MEM;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        RegDst    = 1'b0;
        AluSrc    = 1'b0;
        MemToReg  = 1'b0;
        beq       = 1'b0;
        bgtz      = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        LuiExt    = 1'b0;
        SignExt   = 1'b0;
        ALUOp     = 3'b000;
        GPR_Write = 1'b0;
        DM_Write  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;

        if (state_q != S_FETCH) begin
            case (cls_q)
                C_ADDU: begin RegDst = 1'b1; ALUOp = 3'b000; end
                C_SUBU: begin RegDst = 1'b1; ALUOp = 3'b001; end
                C_ORI:  begin AluSrc = 1'b1; ALUOp = 3'b010; end
                C_LUI:  begin AluSrc = 1'b1; LuiExt = 1'b1; ALUOp = 3'b010; end
                C_LW:   begin AluSrc = 1'b1; SignExt = 1'b1; MemToReg = 1'b1; end
                C_SW:   begin AluSrc = 1'b1; SignExt = 1'b1; end
                C_BEQ:  begin beq = 1'b1; SignExt = 1'b1; ALUOp = 3'b001; end
                C_BGTZ: begin bgtz = 1'b1; SignExt = 1'b1; end
                C_JR:   jr = 1'b1;
                C_JAL:  jal = 1'b1;
                default: ;
            endcase
        end

        // sw completes on the MEM cycle that sees mem_ready, so the PC is
        // loaded and the retire pulse fires exactly once per store.
        case (state_q)
            S_DECODE: illegal = (cls_q == C_ILL);
            S_EXEC: begin
                if (cls_q == C_BEQ || cls_q == C_BGTZ || cls_q == C_JR || cls_q == C_JAL) begin
                    retire = 1'b1;
                end
                GPR_Write = (cls_q == C_JAL);
            end
            S_MEM: begin
                if (cls_q == C_SW) begin
                    DM_Write = 1'b1;
                    retire   = mem_ready;
                end
            end
            S_WB: begin
                GPR_Write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // IR_Write is gated by reset so every output reads 0 while reset is held.
    assign IR_Write    = (state_q == S_FETCH) && reset;
    assign PC_Write    = retire || illegal;
    assign state       = state_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected output vectors are queued
// as each instruction is driven and compared on the falling clock edge.
module tb_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int VW    = 25;

  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_ORI  = 2;
  localparam int K_LUI  = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_BEQ  = 6;
  localparam int K_BGTZ = 7;
  localparam int K_JR   = 8;
  localparam int K_JAL  = 9;
  localparam int K_ILL  = 10;

  logic             clk;
  logic             reset;
  logic [31:0]      Instr;
  logic             mem_ready;
  logic             IR_Write, PC_Write, RegDst, AluSrc, MemToReg;
  logic             beq, bgtz, jal, jr, GPR_Write, DM_Write, LuiExt, SignExt;
  logic [2:0]       ALUOp;
  logic             retire, illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_cnt;

  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  logic [VW-1:0] obs;
  logic [CNT_W-1:0] exp_cnt;

  int errors;
  int checks;

  logic [31:0] instr_tab [10];
  int          kind_tab  [10];

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .mem_ready  (mem_ready),
    .IR_Write   (IR_Write),
    .PC_Write   (PC_Write),
    .RegDst     (RegDst),
    .AluSrc     (AluSrc),
    .MemToReg   (MemToReg),
    .beq        (beq),
    .bgtz       (bgtz),
    .jal        (jal),
    .jr         (jr),
    .GPR_Write  (GPR_Write),
    .DM_Write   (DM_Write),
    .LuiExt     (LuiExt),
    .SignExt    (SignExt),
    .ALUOp      (ALUOp),
    .retire     (retire),
    .illegal    (illegal),
    .state      (state),
    .retired_cnt(retired_cnt)
  );

  assign obs = {state, IR_Write, PC_Write, RegDst, AluSrc, MemToReg, beq, bgtz, jal, jr,
                GPR_Write, DM_Write, LuiExt, SignExt, ALUOp, retire, illegal, retired_cnt};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {7'd0, obs}, {7'd0, e});
    end
  end

  // Drives one instruction starting in its FETCH cycle (called at posedge+1).
  task automatic drive_instr(input logic [31:0] ins, input int k, input int nwait, input string tag);
    int   sts[$];
    logic mr[$];
    int   n;
    sts.push_back(0);
    sts.push_back(1);
    if (k != K_ILL) sts.push_back(2);
    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w <= nwait; w++) sts.push_back(3);
    end
    if (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW) sts.push_back(4);
    n = sts.size();
    for (int i = 0; i < n; i++) begin
      logic [2:0] st;
      logic act, rd, als, m2r, b, bg, j, jrr, lux, sx, lst, ret, ill, pcw, gw, dw, irw, rdy;
      logic [2:0] aop;
      int mem_idx;
      st  = 3'(sts[i]);
      act = (st != 3'd0);
      rd  = act && (k == K_ADDU || k == K_SUBU);
      als = act && (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
      m2r = act && (k == K_LW);
      b   = act && (k == K_BEQ);
      bg  = act && (k == K_BGTZ);
      j   = act && (k == K_JAL);
      jrr = act && (k == K_JR);
      lux = act && (k == K_LUI);
      sx  = act && (k == K_LW || k == K_SW || k == K_BEQ || k == K_BGTZ);
      aop = 3'b000;
      if (act && (k == K_SUBU || k == K_BEQ)) aop = 3'b001;
      if (act && (k == K_ORI || k == K_LUI)) aop = 3'b010;
      lst = (i == n - 1);
      ret = lst && (k != K_ILL);
      ill = lst && (k == K_ILL);
      pcw = lst;
      gw  = (st == 3'd4) || (k == K_JAL && st == 3'd2);
      dw  = (k == K_SW) && (st == 3'd3);
      irw = (st == 3'd0);
      // mem_ready is low for the first nwait MEM cycles, random elsewhere
      mem_idx = i - 3;
      if (st == 3'd3) rdy = (mem_idx >= nwait);
      else rdy = 1'($urandom_range(0, 1));
      Instr     = ins;
      mem_ready = rdy;
      exp_q.push_back({st, irw, pcw, rd, als, m2r, b, bg, j, jrr, gw, dw, lux, sx, aop, ret, ill, exp_cnt});
      tag_q.push_back($sformatf("%s_c%0d", tag, i));
      @(posedge clk);
      #1;
      if (ret) exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_cnt   = '0;
    reset     = 1'b0;
    Instr     = 32'h0;
    mem_ready = 1'b1;
    instr_tab = '{32'h00221821, 32'h00221823, 32'h3422000F, 32'h3C011234, 32'h8C220004,
                  32'hAC220008, 32'h10220003, 32'h1C200002, 32'h03E00008, 32'h0C000010};
    kind_tab  = '{K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BGTZ, K_JR, K_JAL};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {7'd0, obs}, 32'd0);
    reset = 1'b1;

    drive_instr(32'h00221821, K_ADDU, 0, "addu");
    check("cnt_after_addu", {28'd0, retired_cnt}, 32'd1);
    drive_instr(32'h8C220004, K_LW, 3, "lw_wait3");
    drive_instr(32'hAC220008, K_SW, 0, "sw");
    drive_instr(32'h10220003, K_BEQ, 0, "beq");
    drive_instr(32'h0C000010, K_JAL, 0, "jal");
    drive_instr(32'hFC000000, K_ILL, 0, "illegal");
    check("cnt_after_ill", {28'd0, retired_cnt}, {28'd0, exp_cnt});
    drive_instr(32'h00221823, K_SUBU, 0, "subu");
    drive_instr(32'h3422000F, K_ORI, 0, "ori");
    drive_instr(32'h3C011234, K_LUI, 0, "lui");
    drive_instr(32'h1C200002, K_BGTZ, 0, "bgtz");
    drive_instr(32'h03E00008, K_JR, 0, "jr");
    drive_instr(32'h0000002A, K_ILL, 0, "bad_funct");

    // abort a load while it waits in MEM
    Instr     = 32'h8C220004;
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_lw_in_mem", {29'd0, state}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {7'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    exp_cnt = '0;
    check("post_reset_state_cnt", {25'd0, state, retired_cnt}, 32'd0);
    mem_ready = 1'b1;

    // 17 retires from a zeroed 4-bit counter takes it through the wrap
    for (int r = 0; r < 17; r++) begin
      int sel;
      int nw;
      sel = $urandom_range(0, 9);
      nw  = (kind_tab[sel] == K_LW) ? $urandom_range(0, 2) : 0;
      drive_instr(instr_tab[sel], kind_tab[sel], nw, $sformatf("rnd%0d", r));
      if (r == 15) check("cnt_wrap_zero", {28'd0, retired_cnt}, 32'd0);
    end
    check("cnt_final", {28'd0, retired_cnt}, {28'd0, exp_cnt});

    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
